// File: rtl/sfp_sum_link_if.sv
// ---------------------------------------------------------------------------
// sfp_sum_link_if
// One direction of the inter-core sum link: a narrow beat channel.
//
// Handshake: a beat transfers on every rising clk edge where valid && ready.
// While valid is high and ready is low, the master holds data and valid
// stable. ready may depend combinationally on the slave's own state, never on
// valid.
//
// Signals
//   data   master -> slave  one beat of the partial sum (LSB beat first)
//   valid  master -> slave  data holds a beat
//   ready  slave  -> master slave accepts the beat this cycle
// ---------------------------------------------------------------------------
interface sfp_sum_link_if #(
   parameter int bw_link = 8
);
   logic [bw_link-1:0] data;
   logic               valid;
   logic               ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sfp_sum_link.sv
// ---------------------------------------------------------------------------
// sfp_sum_link
// Exchanges the per-row absolute-value partial sum between the two cores.
// The TX side captures this core's final row sum on acc_done and sends it to
// the peer in bw_link-wide beats, LSB beat first. The RX side independently
// reassembles the peer's beats into peer_sum, which feeds this core's SFP row
// as its external sum. xchg_done rises once both directions are complete so
// the division phase only starts with both sums in place.
//
// Ports
//   clk, reset      single clock; asynchronous active-low reset
//   acc_done        one-cycle pulse, local_sum is final and gets captured
//   local_sum       this core's row sum
//   clear           one-cycle pulse, ends the exchange and rearms both sides
//                   (both cores clear in the same cycle)
//   tx              beat channel to the peer (master)
//   rx              beat channel from the peer (slave)
//   peer_sum        reassembled peer sum; keeps its value across clear
//   peer_sum_vld    peer_sum complete and stable
//   xchg_done       both directions complete (registered), held until clear
//   busy            TX sending or RX partially filled
//   err             sticky: acc_done seen while TX was not idle
//   tx_state_dbg    TX state: 0 = T_IDLE, 1 = T_SEND, 2 = T_DONE
//   rx_state_dbg    RX state: 0 = R_RECV, 1 = R_FULL
//   tx_cnt_dbg      beats sent in the current transfer
//   rx_cnt_dbg      beats received in the current sum
// ---------------------------------------------------------------------------
module sfp_sum_link #(
   parameter  int bw_psum_out = 24,
   // must divide bw_psum_out exactly
   parameter  int bw_link     = 8,
   localparam int beats       = bw_psum_out / bw_link,
   localparam int cnt_w       = (beats > 1) ? $clog2(beats) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   acc_done,
   input  logic [bw_psum_out-1:0] local_sum,
   input  logic                   clear,
   sfp_sum_link_if.master         tx,
   sfp_sum_link_if.slave          rx,
   output logic [bw_psum_out-1:0] peer_sum,
   output logic                   peer_sum_vld,
   output logic                   xchg_done,
   output logic                   busy,
   output logic                   err,
   output logic [1:0]             tx_state_dbg,
   output logic                   rx_state_dbg,
   output logic [cnt_w-1:0]       tx_cnt_dbg,
   output logic [cnt_w-1:0]       rx_cnt_dbg
);

   localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_SEND = 2'd1,
      T_DONE = 2'd2
   } tx_state_t;

   typedef enum logic {
      R_RECV = 1'b0,
      R_FULL = 1'b1
   } rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [bw_psum_out-1:0] shreg;
   logic [cnt_w-1:0]       tx_cnt;
   logic [cnt_w-1:0]       rx_cnt;
   logic                   xchg_q;
   logic                   err_q;

   logic capture;   // acc_done accepted in T_IDLE
   logic tx_hs;     // beat leaves this core this cycle
   logic rx_open;   // RX willing to take a beat this cycle
   logic rx_hs;     // beat arrives from the peer this cycle

   // clear beats acc_done: a capture racing a clear would leave TX in T_SEND
   // after the peer has already rearmed.
   assign capture = (tx_state == T_IDLE) && acc_done && !clear;
   assign tx_hs   = (tx_state == T_SEND) && tx.ready && !clear;
   // Gating with reset keeps ready low for the whole reset interval, not just
   // until the state register settles.
   assign rx_open = reset && (rx_state == R_RECV) && !clear;
   assign rx_hs   = rx_open && rx.valid;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= T_IDLE;
         rx_state <= R_RECV;
      end else begin
         tx_state <= tx_next;
         rx_state <= rx_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         T_IDLE: begin
            if (capture) tx_next = T_SEND;
         end
         T_SEND: begin
            // clear aborts a transfer in flight
            if (clear)                             tx_next = T_IDLE;
            else if (tx_hs && tx_cnt == last_beat) tx_next = T_DONE;
         end
         T_DONE: begin
            if (clear) tx_next = T_IDLE;
         end
         default: tx_next = T_IDLE;
      endcase
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_RECV: begin
            if (rx_hs && rx_cnt == last_beat) rx_next = R_FULL;
         end
         R_FULL: begin
            if (clear) rx_next = R_RECV;
         end
         default: rx_next = R_RECV;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      tx.valid     = (tx_state == T_SEND);
      tx.data      = (tx_state == T_SEND) ? shreg[bw_link-1:0] : '0;
      rx.ready     = rx_open;
      peer_sum_vld = (rx_state == R_FULL);
      busy         = (tx_state == T_SEND) ||
                     ((rx_state == R_RECV) && (rx_cnt != '0));
      xchg_done    = xchg_q;
      err          = err_q;
      tx_state_dbg = tx_state;
      rx_state_dbg = rx_state;
      tx_cnt_dbg   = tx_cnt;
      rx_cnt_dbg   = rx_cnt;
   end

   // -------------------------------------------------------------------------
   // TX datapath: the sum shifts right one beat per handshake, so the beat on
   // the wire is always the low slice and stays put while the peer stalls.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg  <= '0;
         tx_cnt <= '0;
      end else if (clear) begin
         tx_cnt <= '0;
      end else if (capture) begin
         shreg  <= local_sum;
         tx_cnt <= '0;
      end else if (tx_hs) begin
         shreg  <= shreg >> bw_link;
         tx_cnt <= tx_cnt + cnt_w'(1);
      end
   end

   // -------------------------------------------------------------------------
   // RX datapath: each accepted beat lands directly in its slice of peer_sum.
   // peer_sum is never cleared outside reset; only peer_sum_vld qualifies it.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         peer_sum <= '0;
         rx_cnt   <= '0;
      end else if (clear) begin
         rx_cnt <= '0;
      end else if (rx_hs) begin
         for (int i = 0; i < beats; i++) begin
            if (rx_cnt == cnt_w'(i)) peer_sum[i*bw_link +: bw_link] <= rx.data;
         end
         rx_cnt <= (rx_cnt == last_beat) ? '0 : rx_cnt + cnt_w'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Completion and error flags
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xchg_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (clear) xchg_q <= 1'b0;
         else if (tx_state == T_DONE && rx_state == R_FULL) xchg_q <= 1'b1;
         // A second acc_done would overwrite a sum already on the wire; it is
         // dropped and flagged instead.
         if (acc_done && !clear && tx_state != T_IDLE) err_q <= 1'b1;
      end
   end

endmodule
